seven_seg_scanner: RTL
======================

Name: seven_seg_scanner

Overview:
- Output-side counterpart of the board's push-button step-pulse input path: drives the multiplexed seven-segment display so the processor's state can be read back.
- Captures a hex word from the datapath on a one-cycle load strobe, holds it in a shadow register, and time-multiplexes it across NUM_DIGITS common-anode digits.
- Each digit slot has a blanking interval to suppress ghosting.
- Shadow-to-display transfer happens only at a frame boundary, so no frame ever shows mixed old/new digits.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; digit 0 is rightmost and shows data_in[3:0].
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz); must be >= 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- load  in  1  capture strobe; sampled each rising edge.
- data_in  in  4*NUM_DIGITS  hex nibbles to display.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- blank_in  in  NUM_DIGITS  per-digit blank mask, 1 = digit dark.
- an  out  NUM_DIGITS  anode enables, active-low.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal-point cathode, active-low.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.

Behaviour:
- Registered state:
  - slot counter cnt, 0..REFRESH_DIV-1.
  - digit index idx, 0..NUM_DIGITS-1.
  - shadow {data, dp, blank}.
  - active {data, dp, blank}.
  - frame_start.
- clear_n low, asynchronous:
  - cnt=0, idx=0, shadow=0, active=0, frame_start=0.
  - Outputs an=all 1, seg=7'h7F, dp=1 for as long as clear_n is low.
  - After release, the first slot is digit 0 with cnt starting at 0.
- Slot FSM, two phases derived from cnt:
  - BLANK (cnt < BLANK_CYCLES): an=all 1, seg=7'h7F, dp=1.
  - DRIVE (cnt >= BLANK_CYCLES): an[idx]=0 and all other anodes 1; seg=hex decode of active nibble idx; dp = ~active_dp[idx].
  - If active_blank[idx]=1 in DRIVE, the anode stays 1 and seg/dp stay all 1.
- an/seg/dp are Moore outputs decoded combinationally from registered cnt, idx and active only. No dependence on load or data_in.
- Each edge:
  - If cnt == REFRESH_DIV-1: cnt←0, and idx←idx+1, wrapping NUM_DIGITS-1→0.
  - Otherwise cnt←cnt+1.
- Frame boundary (the edge where idx wraps to 0):
  - active←shadow.
  - frame_start←1 for exactly one cycle; 0 on all other edges.
  - Frame period is NUM_DIGITS*REFRESH_DIV cycles.
- load=1 at an edge: shadow←{data_in, dp_in, blank_in}. The last load before a boundary wins.
- load coincident with the frame-boundary edge: active takes the OLD shadow, and the new data appears one frame later. There is no bypass.
- Back-to-back loads are legal, with no busy or backpressure.
- Hex decode, seg {g..a} active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset asserted mid-slot: all outputs go dark immediately (asynchronous) and shadow/active are lost. After release, the display shows 0 on all non-blanked digits until the first load plus a frame boundary.
- Widths: cnt is $clog2(REFRESH_DIV) bits and idx is $clog2(NUM_DIGITS) bits, minimum 1. No unused counter states are ever reached.

Test Plan:
All tests use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
1. Release clear_n, no load:
   - Per slot: 2 cycles an=1111, then 6 cycles of an=1110/1101/1011/0111 in turn, seg=1000000, dp=1.
   - Frame period 32 cycles.
2. Load data_in=16'h12AF, dp_in=4'b0100, blank_in=0 mid-frame:
   - Digit 0 keeps showing 0 until the next frame_start.
   - Next frame: digit0 seg=0001110, digit1 0001000, digit2 0100100 with dp=0, digit3 1111001.
3. Assert load with 16'h5555 on the exact frame-boundary edge after a prior load of 16'h3333:
   - The next frame shows 3333 (seg=0110000 on every digit).
   - The following frame shows 5555 (seg=0010010).
4. blank_in=4'b1010 with data_in=16'h8888:
   - Digits 1 and 3 never drive an low.
   - Digits 0 and 2 show seg=0000000.
5. Pull clear_n low at cnt=5 of digit 2:
   - an=1111, seg=7F, dp=1 in the same cycle with no clock edge needed.
   - After release, scanning restarts at digit 0 with cnt=0, showing 0000.
6. Free-run 4 frames:
   - frame_start is high exactly 1 cycle every 32 cycles, coincident with idx=0, cnt=0.
   - No cycle has more than one an bit low.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode 7-segment scanner: shadow register loaded on a strobe, copied to the display at frame boundaries.
// Outputs are decoded from registered scan state. A load lands one boundary later. There is no backpressure: loads are accepted every cycle.
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      clear_n,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic                      frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
  } disp_t;

  typedef enum logic {PH_BLANK, PH_DRIVE} phase_t;

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  disp_t         shadow;
  disp_t         active;
  phase_t        phase;
  logic [3:0]    nib;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Nonblocking update means a load on the boundary edge misses this frame.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '0;
      active      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (load) begin
        shadow <= {data_in, dp_in, blank_in};
      end
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (idx == IDX_LAST) begin
          idx         <= '0;
          active      <= shadow;
          frame_start <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Gating on clear_n keeps the display dark in reset even with BLANK_CYCLES = 0.
  always_comb begin
    phase = (clear_n && (int'(cnt) >= BLANK_CYCLES)) ? PH_DRIVE : PH_BLANK;
    nib   = active.data[int'(idx)*4 +: 4];
    an    = '1;
    seg   = 7'h7F;
    dp    = 1'b1;
    if (phase == PH_DRIVE && !active.blank[idx]) begin
      an[idx] = 1'b0;
      seg     = hex7(nib);
      dp      = ~active.dp[idx];
    end
  end

endmodule
